// File: rtl/char_rom_patch_table_if.sv
// Config port bundle for char_rom_patch_table.
// CHARROM_PATCH_READBACK_EN adds the readback response signals cfg_rvalid/cfg_rdata.
interface char_rom_patch_table_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 5
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;

`ifdef CHARROM_PATCH_READBACK_EN
  logic                     cfg_rvalid;
  logic [ADDR_W+DATA_W:0]   cfg_rdata;

  modport master (
    output cfg_valid, cfg_op, cfg_idx, cfg_addr, cfg_data,
    input  cfg_ready, cfg_rvalid, cfg_rdata
  );
  modport slave (
    input  cfg_valid, cfg_op, cfg_idx, cfg_addr, cfg_data,
    output cfg_ready, cfg_rvalid, cfg_rdata
  );
`else
  modport master (
    output cfg_valid, cfg_op, cfg_idx, cfg_addr, cfg_data,
    input  cfg_ready
  );
  modport slave (
    input  cfg_valid, cfg_op, cfg_idx, cfg_addr, cfg_data,
    output cfg_ready
  );
`endif
endinterface

// File: rtl/char_rom_patch_table.sv
// Run-time loadable glyph patch table between character ROM and video shifter.
// Optional readback of entries (op 11) when CHARROM_PATCH_READBACK_EN is defined.
module char_rom_patch_table #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              override,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] q,
  output logic              patch,
  output logic              busy,
  output logic [15:0]       hit_count,
  char_rom_patch_table_if.slave cfg
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [1:0] OpWrite   = 2'b00;
  localparam logic [1:0] OpDisable = 2'b01;
  localparam logic [1:0] OpClear   = 2'b10;
  localparam logic [1:0] OpRead    = 2'b11;

  state_e             state_q;
  logic [IDX_W-1:0]   sweep_q;
  logic               cfg_ready_q;
  logic               busy_q;
  logic [ENTRIES-1:0] valid_q;
  logic [ADDR_W-1:0]  addr_q [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [DATA_W-1:0]  glyph_q;
  logic               patch_q;
  logic [15:0]        hit_count_q;

  logic               xfer;
  logic               clear_start;
  logic               hit;
  logic [DATA_W-1:0]  hit_data;

  assign xfer        = cfg.cfg_valid && cfg_ready_q;
  assign clear_start = xfer && (cfg.cfg_op == OpClear);

  // Walk from the top index down so the lowest matching entry is the last to win.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == a)) begin
        hit      = 1'b1;
        hit_data = data_q[i];
      end
    end
    hit = hit && override && (state_q == StIdle);
  end

  // Control FSM, valid bits and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sweep_q     <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= '0;
`ifdef CHARROM_PATCH_READBACK_EN
      cfg.cfg_rvalid <= 1'b0;
      cfg.cfg_rdata  <= '0;
`endif
    end else begin
`ifdef CHARROM_PATCH_READBACK_EN
      cfg.cfg_rvalid <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            unique case (cfg.cfg_op)
              OpWrite:   valid_q[cfg.cfg_idx] <= 1'b1;
              OpDisable: valid_q[cfg.cfg_idx] <= 1'b0;
              OpClear: begin
                state_q     <= StClear;
                sweep_q     <= '0;
                cfg_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end
              OpRead: begin
`ifdef CHARROM_PATCH_READBACK_EN
                cfg.cfg_rvalid <= 1'b1;
                cfg.cfg_rdata  <= {valid_q[cfg.cfg_idx], addr_q[cfg.cfg_idx],
                                   data_q[cfg.cfg_idx]};
`endif
              end
              default: ;
            endcase
          end
        end
        StClear: begin
          valid_q[sweep_q] <= 1'b0;
          sweep_q          <= sweep_q + 1'b1;
          if (sweep_q == IDX_W'(ENTRIES - 1)) begin
            state_q     <= StIdle;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Address/data payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (xfer && (cfg.cfg_op == OpWrite)) begin
      addr_q[cfg.cfg_idx] <= cfg.cfg_addr;
      data_q[cfg.cfg_idx] <= cfg.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_q     <= '0;
      patch_q     <= 1'b0;
      hit_count_q <= '0;
    end else begin
      glyph_q <= hit ? hit_data : rom_q;
      patch_q <= hit;
      if (clear_start) begin
        hit_count_q <= '0;
      end else if (hit && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
    end
  end

  assign q             = glyph_q;
  assign patch         = patch_q;
  assign busy          = busy_q;
  assign hit_count     = hit_count_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_char_rom_patch_table.sv
// Scoreboard bench for char_rom_patch_table: stimulus queues expected lookup results,
// a negedge monitor pops and compares them on the cycle the DUT presents them.
module tb_char_rom_patch_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        override = 1'b0;
  logic [10:0] a = '0;
  logic [7:0]  rom_q = '0;
  logic [7:0]  q;
  logic        patch;
  logic        busy;
  logic [15:0] hit_count;

  char_rom_patch_table_if #(.ADDR_W(11), .DATA_W(8), .IDX_W(5)) cfg_if ();

  char_rom_patch_table #(.ADDR_W(11), .DATA_W(8), .ENTRIES(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .override  (override),
    .a         (a),
    .rom_q     (rom_q),
    .q         (q),
    .patch     (patch),
    .busy      (busy),
    .hit_count (hit_count),
    .cfg       (cfg_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  q;
    logic        patch;
    logic [15:0] hc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t e;
  logic [10:0] clr_addr [3] = '{11'h100, 11'h1A7, 11'h2B3};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: outputs are registered, so compare on the negedge after the sampling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: check scheduled for cycle %0d, reached at %0d", e.nm, e.cyc, cyc);
      end else begin
        cmp({e.nm, ".q"}, 32'(q), 32'(e.q));
        cmp({e.nm, ".patch"}, 32'(patch), 32'(e.patch));
        cmp({e.nm, ".hit_count"}, 32'(hit_count), 32'(e.hc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(string nm, logic [7:0] eq, logic ep, logic [15:0] ehc);
    exp_t x;
    x.cyc   = cyc + 1;
    x.q     = eq;
    x.patch = ep;
    x.hc    = ehc;
    x.nm    = nm;
    sb.push_back(x);
  endfunction

  task automatic lookup(input string nm, input logic [10:0] ad, input logic [7:0] rom,
                        input logic ov, input logic [7:0] eq, input logic ep,
                        input logic [15:0] ehc);
    override = ov;
    a        = ad;
    rom_q    = rom;
    push(nm, eq, ep, ehc);
    step();
    override = 1'b0;
  endtask

  task automatic cfg_xfer(input logic [1:0] op, input logic [4:0] idx,
                          input logic [10:0] ad, input logic [7:0] d);
    int t;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = op;
    cfg_if.cfg_idx   = idx;
    cfg_if.cfg_addr  = ad;
    cfg_if.cfg_data  = d;
    t = 0;
    while (!cfg_if.cfg_ready && t < 64) begin
      step();
      t++;
    end
    if (!cfg_if.cfg_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL cfg_ready_timeout: got 0, expected 1");
    end
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_op    = 2'b00;
    cfg_if.cfg_idx   = '0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_data  = '0;
    repeat (3) step();
    cmp("reset.q", 32'(q), 32'h0);
    cmp("reset.patch", 32'(patch), 32'h0);
    cmp("reset.ready_busy", 32'({cfg_if.cfg_ready, busy}), 32'b10);
    cmp("reset.hit_count", 32'(hit_count), 32'h0);
    rst_n = 1'b1;
    step();

    // Empty table: ROM data passes through.
    lookup("empty", 11'h100, 8'h3C, 1'b1, 8'h3C, 1'b0, 16'd0);

    // Single entry hit, then override gating.
    cfg_xfer(2'b00, 5'd0, 11'h100, 8'hFF);
    lookup("hit0", 11'h100, 8'h3C, 1'b1, 8'hFF, 1'b1, 16'd1);
    lookup("no_override", 11'h100, 8'h3C, 1'b0, 8'h3C, 1'b0, 16'd1);

    // Priority: idx1 beats idx3 on the same address; disabling idx1 exposes idx3.
    cfg_xfer(2'b00, 5'd3, 11'h1A7, 8'hF8);
    cfg_xfer(2'b00, 5'd1, 11'h1A7, 8'h03);
    lookup("prio_low", 11'h1A7, 8'h55, 1'b1, 8'h03, 1'b1, 16'd2);
    cfg_xfer(2'b01, 5'd1, 11'h000, 8'h00);
    lookup("after_disable", 11'h1A7, 8'h55, 1'b1, 8'hF8, 1'b1, 16'd3);
    lookup("miss", 11'h1A6, 8'h66, 1'b1, 8'h66, 1'b0, 16'd3);

    // Write and lookup on the same edge: old contents seen.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = 2'b00;
    cfg_if.cfg_idx   = 5'd5;
    cfg_if.cfg_addr  = 11'h2B3;
    cfg_if.cfg_data  = 8'hA5;
    lookup("same_edge", 11'h2B3, 8'h11, 1'b1, 8'h11, 1'b0, 16'd3);
    cfg_if.cfg_valid = 1'b0;
    lookup("next_edge", 11'h2B3, 8'h11, 1'b1, 8'hA5, 1'b1, 16'd4);

    // Clear all: 32 busy cycles with every lookup missing.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = 2'b10;
    step();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cmp("clear.busy_ready", 32'({busy, cfg_if.cfg_ready}), 32'b10);
      lookup("clear.lookup", clr_addr[i % 3], 8'(i), 1'b1, 8'(i), 1'b0, 16'd0);
    end
    cmp("post_clear.busy_ready", 32'({busy, cfg_if.cfg_ready}), 32'b01);
    for (int i = 0; i < 3; i++) begin
      lookup("post_clear.miss", clr_addr[i], 8'h5A, 1'b1, 8'h5A, 1'b0, 16'd0);
    end

    // Saturating hit counter.
    cfg_xfer(2'b00, 5'd7, 11'h3FF, 8'hC3);
    override = 1'b1;
    a        = 11'h3FF;
    rom_q    = 8'h00;
    repeat (65540) step();
    cmp("sat.hit_count", 32'(hit_count), 32'hFFFF);
    lookup("sat.lookup", 11'h3FF, 8'h00, 1'b1, 8'hC3, 1'b1, 16'hFFFF);

    // Reset in the middle of a clear sweep.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = 2'b10;
    step();
    cfg_if.cfg_valid = 1'b0;
    repeat (5) step();
    cmp("mid_clear.busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    cmp("mid_reset.busy_ready", 32'({busy, cfg_if.cfg_ready}), 32'b01);
    cmp("mid_reset.patch_hc", 32'({patch, hit_count}), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    lookup("after_reset.e7", 11'h3FF, 8'h77, 1'b1, 8'h77, 1'b0, 16'd0);
    lookup("after_reset.e0", 11'h100, 8'h78, 1'b1, 8'h78, 1'b0, 16'd0);

    repeat (3) step();
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/char_rom_patch_table.md
Name: char_rom_patch_table

Overview:
Run-time loadable character-generator patch table that sits between the character ROM and the video shifter. Each valid table entry replaces the ROM byte at one glyph address with a programmed byte. Entries are loaded through a ready/valid config port driven by the CPU bus bridge. This generalises the old fixed, hard-coded patch list to N programmable entries, and adds clear-all, a lookup priority rule and a hit counter.

Parameters:
ADDR_W, 11, character ROM address width.
DATA_W, 8, glyph row data width.
ENTRIES, 32, number of patch entries; power of two, 2..64.
IDX_W, $clog2(ENTRIES), entry index width (derived; do not override).

Ports:
clk  in  1  system clock, all logic rising-edge.
rst_n  in  1  asynchronous active-low reset.
override  in  1  patching enabled for this lookup.
a  in  ADDR_W  character ROM address of the current lookup.
rom_q  in  DATA_W  unpatched ROM data for address a, same cycle as a.
q  out  DATA_W  final glyph data, registered.
patch  out  1  high when q came from the table, registered.
cfg_valid  in  1  config request.
cfg_ready  out  1  config request accepted when valid and ready are both high.
cfg_op  in  2  00 write entry, 01 disable entry, 10 clear all, 11 readback (optional).
cfg_idx  in  IDX_W  target entry.
cfg_addr  in  ADDR_W  match address for a write.
cfg_data  in  DATA_W  replacement byte for a write.
busy  out  1  clear sweep in progress.
hit_count  out  16  saturating count of cycles with patch=1.

Behaviour:
- Reset (async, rst_n=0): all entry valid bits=0; q=0, patch=0, cfg_ready=1, busy=0, hit_count=0; FSM=IDLE. Reset mid-sweep aborts the sweep; the table is invalid after reset anyway.
- Lookup, latency 1: a, override and rom_q sampled at edge N; q and patch are valid after edge N.
  - Hit = override=1, table not clearing, and some valid entry with addr==a.
  - On hit: q=that entry's data, patch=1. Otherwise q=rom_q, patch=0.
  - Multiple matching entries: the lowest index wins.
- Table storage is registers: ENTRIES x {valid, ADDR_W addr, DATA_W data}.
- Config handshake: a transfer occurs on an edge with cfg_valid&cfg_ready. The requester holds its fields stable until ready. cfg_ready = (state==IDLE).
- op 00: entry[idx] <= {1, addr, data} on the transfer edge.
- op 01: entry[idx].valid <= 0; addr and data unchanged.
- Write/lookup ordering: a config write takes effect for lookups sampled on the following edge. A lookup on the same edge as the write sees the old contents.
- op 10: go IDLE->CLEAR and zero hit_count.
  - CLEAR: sweep counter 0..ENTRIES-1, one valid bit cleared per cycle. busy=1, cfg_ready=0. Every lookup returns patch=0, q=rom_q.
  - After clearing entry ENTRIES-1, return to IDLE. The whole op takes ENTRIES cycles; cfg_ready returns high on the next cycle.
- hit_count: +1 on each cycle that patch goes 1; saturates at 16'hFFFF; no wrap.
- op 11 without the macro: accepted (one-cycle handshake), no effect.

Optional Feature:
CHARROM_PATCH_READBACK_EN
- Defined: adds output ports cfg_rvalid (1) and cfg_rdata (1+ADDR_W+DATA_W, {valid,addr,data}). An accepted op 11 produces cfg_rvalid=1 for exactly one cycle on the following cycle, with entry[idx] contents as of the accept edge. cfg_rvalid=0 and cfg_rdata=0 out of reset.
- Not defined: these ports are absent and op 11 is a no-op.

Test Plan:
- Reset, then override=1, a=11'h100, rom_q=8'h3C -> next cycle q=8'h3C, patch=0, hit_count=0.
- Write idx0={11'h100, 8'hFF}; next-cycle lookup a=11'h100 -> q=8'hFF, patch=1, hit_count=1. Same lookup with override=0 -> q=rom_q, patch=0.
- Write idx3={11'h1A7, 8'hF8} and idx1={11'h1A7, 8'h03}; lookup 11'h1A7 -> q=8'h03 (lowest index wins). Disable idx1, then lookup -> q=8'hF8.
- Write idx5 and look up its address on the same edge -> old result (patch=0); the following cycle gives patch=1.
- Issue clear with ENTRIES=32 -> busy=1 and cfg_ready=0 for 32 cycles, all lookups patch=0, hit_count=0. Afterwards cfg_ready=1 and the old addresses miss.
- Drive 65540 consecutive hits -> hit_count holds 16'hFFFF. Assert rst_n=0 mid-clear -> busy=0, all entries miss.
